// File: rtl/pattern_scan_pkg.sv
// Shared types and defaults for the pattern scan controller.
package pattern_scan_pkg;

    localparam int unsigned PAT_W_DEF  = 4;
    localparam int unsigned WORD_W_DEF = 8;
    localparam int unsigned CNT_W_DEF  = 8;

    // Wide enough for the largest supported pattern; sliced to PAT_W at use.
    localparam logic [7:0] RST_PATTERN = 8'h00;
    localparam logic       RST_OVERLAP = 1'b1;

    typedef enum logic [1:0] {
        StIdle,
        StArmed,
        StShift
    } state_e;

endpackage

// File: rtl/pattern_scan_ctrl_match.sv
// Serial pattern matcher: history shift register, fill counter, compare, overlap.
// match is combinational: high when the bit shifted at the coming edge completes a match.
module pattern_match #(
    parameter int unsigned PAT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             shift_en,
    input  logic             bit_in,
    input  logic [PAT_W-1:0] pattern,
    input  logic             overlap,
    output logic             match
);

    localparam int unsigned FILL_W = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W);

    logic [PAT_W-1:0]  hist_q, hist_d;
    logic [FILL_W-1:0] fill_q, fill_sh;
    logic              hit;

    always_comb begin
        hist_d  = {hist_q[PAT_W-2:0], bit_in};
        fill_sh = (fill_q == FILL_MAX) ? fill_q : fill_q + 1'b1;
        hit     = shift_en && (fill_sh == FILL_MAX) && (hist_d == pattern);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q <= '0;
            fill_q <= '0;
        end else if (clr) begin
            hist_q <= '0;
            fill_q <= '0;
        end else if (shift_en) begin
            hist_q <= hist_d;
            // Non-overlapping mode: the matched bits cannot seed the next match.
            fill_q <= (hit && !overlap) ? '0 : fill_sh;
        end
    end

    assign match = hit;

endmodule

// File: rtl/pattern_scan_ctrl.sv
// Word-to-serial front end for the pattern matcher with match counter and sticky irq.
// Optional feature macro: PSCAN_IRQ_EN enables the threshold register and irq.
module pattern_scan_ctrl
    import pattern_scan_pkg::*;
#(
    parameter int unsigned PAT_W  = PAT_W_DEF,
    parameter int unsigned WORD_W = WORD_W_DEF,
    parameter int unsigned CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_we,
    input  logic [PAT_W-1:0]  cfg_pattern,
    input  logic              cfg_overlap,
    input  logic [CNT_W-1:0]  cfg_thresh,
    input  logic              start,
    input  logic              stop,
    input  logic              irq_clr,
    input  logic              in_valid,
    input  logic [WORD_W-1:0] in_data,
    output logic              in_ready,
    output logic              bit_out,
    output logic              match,
    output logic [CNT_W-1:0]  match_cnt,
    output logic              irq,
    output logic              busy
);

    localparam int unsigned IDX_W = $clog2(WORD_W);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORD_W - 1);

    state_e            state_q;
    logic [WORD_W-1:0] word_q;
    logic [IDX_W-1:0]  idx_q;
    logic              stop_pend_q;
    logic              bit_out_q;
    logic              match_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [PAT_W-1:0]  pattern_q;
    logic              overlap_q;

    logic arm, cfg_wr, shift_en, hit;

    assign arm      = start && (state_q == StIdle);
    assign cfg_wr   = cfg_we && (state_q == StIdle);
    assign shift_en = (state_q == StShift);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            word_q      <= '0;
            idx_q       <= '0;
            stop_pend_q <= 1'b0;
            bit_out_q   <= 1'b0;
            match_q     <= 1'b0;
        end else begin
            match_q <= hit;
            unique case (state_q)
                StIdle: begin
                    if (start) state_q <= StArmed;
                end
                StArmed: begin
                    if (stop) begin
                        state_q <= StIdle;
                    end else if (in_valid) begin
                        state_q   <= StShift;
                        word_q    <= {in_data[WORD_W-2:0], 1'b0};
                        bit_out_q <= in_data[WORD_W-1];
                        idx_q     <= '0;
                    end
                end
                StShift: begin
                    if (idx_q == IDX_LAST) begin
                        state_q     <= (stop || stop_pend_q) ? StIdle : StArmed;
                        stop_pend_q <= 1'b0;
                        bit_out_q   <= 1'b0;
                    end else begin
                        idx_q     <= idx_q + 1'b1;
                        word_q    <= {word_q[WORD_W-2:0], 1'b0};
                        bit_out_q <= word_q[WORD_W-1];
                        if (stop) stop_pend_q <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pattern_q <= RST_PATTERN[PAT_W-1:0];
            overlap_q <= RST_OVERLAP;
        end else if (cfg_wr) begin
            pattern_q <= cfg_pattern;
            overlap_q <= cfg_overlap;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (arm) begin
            cnt_q <= '0;
        end else if (hit && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    pattern_match #(
        .PAT_W (PAT_W)
    ) u_match (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (arm),
        .shift_en (shift_en),
        .bit_in   (bit_out_q),
        .pattern  (pattern_q),
        .overlap  (overlap_q),
        .match    (hit)
    );

`ifdef PSCAN_IRQ_EN
    logic [CNT_W-1:0] thresh_q;
    logic [CNT_W-1:0] cnt_inc;
    logic             irq_q;
    logic             irq_set;

    assign cnt_inc = cnt_q + 1'b1;
    // Fires only on the increment that reaches the threshold, not while parked there.
    assign irq_set = hit && (cnt_q != '1) && (thresh_q != '0) && (cnt_inc == thresh_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            thresh_q <= '0;
            irq_q    <= 1'b0;
        end else begin
            if (cfg_wr) thresh_q <= cfg_thresh;
            if (irq_set) begin
                irq_q <= 1'b1;
            end else if (irq_clr || arm) begin
                irq_q <= 1'b0;
            end
        end
    end

    assign irq = irq_q;
`else
    logic unused_irq_cfg;
    assign unused_irq_cfg = ^{cfg_thresh, irq_clr};
    assign irq = 1'b0;
`endif

    assign in_ready  = (state_q == StArmed);
    assign busy      = (state_q == StArmed) || (state_q == StShift);
    assign bit_out   = bit_out_q;
    assign match     = match_q;
    assign match_cnt = cnt_q;

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Directed self-checking bench for pattern_scan_ctrl (PAT_W=4, WORD_W=8, CNT_W=8).
module tb_pattern_scan_ctrl;

`ifdef PSCAN_IRQ_EN
    localparam logic IRQ_EN = 1'b1;
`else
    localparam logic IRQ_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cfg_we = 1'b0;
    logic [3:0] cfg_pattern = '0;
    logic       cfg_overlap = 1'b1;
    logic [7:0] cfg_thresh = '0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       irq_clr = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = '0;
    logic       in_ready, bit_out, match, irq, busy;
    logic [7:0] match_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pattern_scan_ctrl #(
        .PAT_W  (4),
        .WORD_W (8),
        .CNT_W  (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_we      (cfg_we),
        .cfg_pattern (cfg_pattern),
        .cfg_overlap (cfg_overlap),
        .cfg_thresh  (cfg_thresh),
        .start       (start),
        .stop        (stop),
        .irq_clr     (irq_clr),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .bit_out     (bit_out),
        .match       (match),
        .match_cnt   (match_cnt),
        .irq         (irq),
        .busy        (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_cfg(input logic [3:0] p, input logic ov, input logic [7:0] th);
        cfg_we = 1'b1; cfg_pattern = p; cfg_overlap = ov; cfg_thresh = th;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1; tick(); stop = 1'b0;
    endtask

    // Sends one word; mm[k] is the match output seen in the cycle after bit k shifts in.
    task automatic send_word(input logic [7:0] d, output logic [7:0] mm, output logic bo_ok);
        int w;
        w = 0; mm = '0; bo_ok = 1'b1;
        while (!in_ready && w < 20) begin tick(); w++; end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL send_word_ready: in_ready=%b required 1", in_ready);
            return;
        end
        in_valid = 1'b1; in_data = d;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (bit_out !== d[7-k]) bo_ok = 1'b0;
            tick();
            mm[k] = match;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if ({bit_out, match, irq} !== 3'b000) begin errors++; $display("FAIL reset_outs: got %b want 000", {bit_out, match, irq}); end
        checks++; if (match_cnt !== 8'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", match_cnt); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_overlap();
        logic [7:0] mm; logic ok;
        write_cfg(4'b1010, 1'b1, 8'd0);
        pulse_start();
        checks++; if ({in_ready, busy} !== 2'b11) begin errors++; $display("FAIL armed_flags: got %b want 11", {in_ready, busy}); end
        send_word(8'hAA, mm, ok);
        checks++; if (mm !== 8'b1010_1000) begin errors++; $display("FAIL overlap_mask: got %b want 10101000", mm); end
        checks++; if (match_cnt !== 8'd3) begin errors++; $display("FAIL overlap_cnt: got %0d want 3", match_cnt); end
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL overlap_bit_out: got %b want 1", ok); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL ready_after_word: got %b want 1", in_ready); end
        pulse_start();
        checks++; if ({in_ready, match_cnt} !== {1'b1, 8'd3}) begin errors++; $display("FAIL start_ignored: got %b/%0d want 1/3", in_ready, match_cnt); end
        pulse_stop();
    endtask

    task automatic test_no_overlap();
        logic [7:0] mm; logic ok;
        write_cfg(4'b1010, 1'b0, 8'd0);
        pulse_start();
        send_word(8'hAA, mm, ok);
        checks++; if (mm !== 8'b1000_1000) begin errors++; $display("FAIL nooverlap_mask: got %b want 10001000", mm); end
        checks++; if (match_cnt !== 8'd2) begin errors++; $display("FAIL nooverlap_cnt: got %0d want 2", match_cnt); end
        pulse_stop();
    endtask

    task automatic test_back_to_back();
        logic [7:0] mm0, mm1; logic ok;
        write_cfg(4'b1010, 1'b1, 8'd0);
        pulse_start();
        send_word(8'h05, mm0, ok);
        send_word(8'h7F, mm1, ok);
        checks++; if (mm0 !== 8'h00) begin errors++; $display("FAIL cross_first: got %b want 00000000", mm0); end
        checks++; if (mm1 !== 8'b0000_0001) begin errors++; $display("FAIL cross_second: got %b want 00000001", mm1); end
        checks++; if (match_cnt !== 8'd1) begin errors++; $display("FAIL cross_cnt: got %0d want 1", match_cnt); end
        pulse_stop();
    endtask

    task automatic test_stop_mid_shift();
        write_cfg(4'b1010, 1'b1, 8'd0);
        pulse_start();
        in_valid = 1'b1; in_data = 8'hAA;
        tick();
        in_valid = 1'b0;
        tick(); tick();
        stop = 1'b1; cfg_we = 1'b1; cfg_pattern = 4'b1111;
        tick();
        stop = 1'b0; cfg_we = 1'b0;
        repeat (4) tick();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL stop_word_completes: busy=%b want 1", busy); end
        tick();
        checks++; if ({in_ready, busy} !== 2'b00) begin errors++; $display("FAIL stop_idle: got %b want 00", {in_ready, busy}); end
        checks++; if (match_cnt !== 8'd3) begin errors++; $display("FAIL cfg_locked: cnt=%0d want 3", match_cnt); end
        // stop beats a same-cycle handshake in ARMED
        pulse_start();
        in_valid = 1'b1; in_data = 8'hAA; stop = 1'b1;
        tick();
        in_valid = 1'b0; stop = 1'b0;
        tick();
        checks++; if ({in_ready, busy} !== 2'b00) begin errors++; $display("FAIL stop_priority: got %b want 00", {in_ready, busy}); end
    endtask

    task automatic test_irq();
        logic [7:0] mm; logic ok;
        write_cfg(4'b1010, 1'b1, 8'd2);
        pulse_start();
        send_word(8'hA0, mm, ok);
        checks++; if ({match_cnt, irq} !== {8'd1, 1'b0}) begin errors++; $display("FAIL irq_first: got %0d/%b want 1/0", match_cnt, irq); end
        send_word(8'hA0, mm, ok);
        checks++; if ({match_cnt, irq} !== {8'd2, IRQ_EN}) begin errors++; $display("FAIL irq_set: got %0d/%b want 2/%b", match_cnt, irq, IRQ_EN); end
        irq_clr = 1'b1; tick(); irq_clr = 1'b0;
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_clr: got %b want 0", irq); end
        pulse_stop();
    endtask

    task automatic test_saturate();
        logic [7:0] mm; logic ok; int total;
        total = 0;
        write_cfg(4'b1111, 1'b1, 8'd0);
        pulse_start();
        for (int i = 0; i < 40; i++) begin
            send_word(8'hFF, mm, ok);
            total += $countones(mm);
        end
        checks++; if (total < 300) begin errors++; $display("FAIL sat_pulses: got %0d want >=300", total); end
        checks++; if (match_cnt !== 8'd255) begin errors++; $display("FAIL sat_cnt: got %0d want 255", match_cnt); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL thresh0_irq: got %b want 0", irq); end
    endtask

    task automatic test_reset_mid_shift();
        logic [7:0] mm; logic ok;
        // Still armed with count 255; leave stale 1101 in history before reset.
        in_valid = 1'b1; in_data = 8'hA0;
        tick();
        in_valid = 1'b0;
        tick(); tick(); tick();
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({in_ready, busy, match, irq, bit_out} !== 5'b0) begin errors++; $display("FAIL async_reset_flags: got %b want 00000", {in_ready, busy, match, irq, bit_out}); end
        checks++; if (match_cnt !== 8'd0) begin errors++; $display("FAIL async_reset_cnt: got %0d want 0", match_cnt); end
        tick();
        rst_n = 1'b1;
        tick();
        write_cfg(4'b1010, 1'b1, 8'd0);
        pulse_start();
        send_word(8'h3F, mm, ok);
        checks++; if (mm !== 8'h00) begin errors++; $display("FAIL stale_history: got %b want 00000000", mm); end
        checks++; if (match_cnt !== 8'd0) begin errors++; $display("FAIL stale_cnt: got %0d want 0", match_cnt); end
    endtask

    initial begin
        test_reset();
        test_overlap();
        test_no_overlap();
        test_back_to_back();
        test_stop_mid_shift();
        test_irq();
        test_saturate();
        test_reset_mid_shift();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pattern_scan_ctrl.md
# pattern_scan_ctrl

Front-end controller for the serial pattern detector on the MAX10 board. It accepts parallel words over a valid/ready handshake and serialises them MSB-first into a programmable PAT_W-bit pattern matcher. It counts matches and raises a sticky interrupt at a programmed threshold. It arms and disarms the stream, gates configuration writes, and keeps match history continuous across word boundaries.

## Interface
- PAT_W, 4: pattern length in bits (2..8)
- WORD_W, 8: input word width
- CNT_W, 8: match counter width
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- cfg_we  in  1  config write strobe; honoured only in IDLE
- cfg_pattern  in  PAT_W  pattern; bit PAT_W-1 is the oldest bit
- cfg_overlap  in  1  1 = overlapping matches allowed
- cfg_thresh  in  CNT_W  irq threshold; 0 = irq never fires
- start  in  1  arm: clear history, count and irq, then go to ARMED
- stop  in  1  disarm request
- irq_clr  in  1  clear sticky irq
- in_valid  in  1  word valid
- in_data  in  WORD_W  word, shifted MSB first
- in_ready  out  1  high only in ARMED
- bit_out  out  1  bit currently being shifted (observability)
- match  out  1  one-cycle pulse per match
- match_cnt  out  CNT_W  saturating match count
- irq  out  1  sticky threshold interrupt
- busy  out  1  high in ARMED and SHIFT

## Operation
- FSM states:
  - IDLE: config registers writable; in_ready=0.
  - ARMED: in_ready=1; waits for a word.
  - SHIFT: one bit per cycle for WORD_W cycles.
- Transitions:
  - IDLE→ARMED on start.
  - ARMED→SHIFT on in_valid&&in_ready; word latched at that edge.
  - ARMED→IDLE on stop; stop has priority over a same-cycle handshake, and that word is not accepted.
  - SHIFT→ARMED after bit index WORD_W-1. If stop arrived at any point during SHIFT, go SHIFT→IDLE instead. The current word always completes.
  - start outside IDLE is ignored.
- History:
  - PAT_W-bit shift register hist, plus fill counter saturating at PAT_W.
  - Each SHIFT cycle shifts bit_out into hist LSB.
  - Match when the post-shift fill ≥ PAT_W and hist == cfg_pattern.
  - When cfg_overlap=0, a match resets fill to 0.
  - hist and fill persist across words and ARMED gaps; they clear only on start or reset.
- Counter:
  - Increments on each match.
  - Saturates at 2^CNT_W-1; no wrap.
- irq:
  - Set on the edge where match_cnt becomes equal to a nonzero cfg_thresh.
  - Cleared by irq_clr or start. If set and clear happen together, set wins.
- cfg_we outside IDLE is ignored. Configuration is stable for the whole armed session.

## Timing
- Reset values: state=IDLE, in_ready=0, bit_out=0, match=0, match_cnt=0, irq=0, busy=0, hist=0, fill=0. Config registers reset to pattern=0, overlap=1, thresh=0.
- Handshake accepted at edge T:
  - Cycles T+1..T+WORD_W are SHIFT, with bit_out = in_data[WORD_W-1-k] in cycle T+1+k.
  - in_ready is high again in cycle T+WORD_W+1.
  - Peak throughput is one word per WORD_W+1 cycles.
- Latency: match is a registered pulse, high in the cycle after the edge where the completing bit enters hist. match_cnt and irq update on that same edge.
- Reset mid-SHIFT aborts the word immediately. No partial match is reported.

## Configuration
- PSCAN_IRQ_EN defined: threshold compare, irq, irq_clr and the cfg_thresh register are present.
- PSCAN_IRQ_EN undefined: irq is tied 0; cfg_thresh and irq_clr are ignored; no threshold register. Counting and matching are unchanged.

## Structure
- Package pattern_scan_pkg holds:
  - the state enum typedef (IDLE, ARMED, SHIFT);
  - default width localparams;
  - the reset pattern and overlap constants.
- One sub-module, pattern_match, contains hist, fill, the compare and overlap handling. Its ports are clk, rst_n, clr, shift_en, bit_in, pattern, overlap and match.
- Top level holds the FSM, word register, bit index, counter and irq.

## Test plan
- pattern=4'b1010, overlap=1, word 8'hAA → 3 match pulses (after bits 3, 5, 7); match_cnt=3.
- Same pattern and word with overlap=0 → 2 matches (after bits 3 and 7); match_cnt=2.
- Cross-boundary: words 8'h05 then 8'h7F, overlap=1 → exactly 1 match, pulsing in the cycle after the first bit of the second word is shifted in.
- stop asserted at SHIFT bit 2 → word completes, then IDLE with in_ready=0. A cfg_we during SHIFT leaves the pattern unchanged.
- thresh=2, two 8'hA0 words (one match each) → irq rises with match_cnt=2. irq_clr drops it. Feeding 300 matches with CNT_W=8 saturates match_cnt at 255.
- rst_n low mid-SHIFT → all outputs at reset values asynchronously. After start, no stale match comes from pre-reset history.
